// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator
// and the downstream pixel generators.
package vga_timing_pkg;

  localparam int H_DISP  = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;

  localparam int V_DISP  = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;

  localparam int H_TOTAL =
    H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISP + V_FRONT + V_SYNC + V_BACK;

  localparam int H_RETRACE_START = H_DISP + H_FRONT;
  localparam int H_RETRACE_END   =
    H_DISP + H_FRONT + H_SYNC - 1;
  localparam int V_RETRACE_START = V_DISP + V_FRONT;
  localparam int V_RETRACE_END   =
    V_DISP + V_FRONT + V_SYNC - 1;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  // Map a raw retrace term onto the pin level for a polarity.
  function automatic logic sync_level(
    input logic retrace,
    input logic pol
  );
    return pol ? retrace : ~retrace;
  endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with a terminal-count decode,
// used as the pixel tick divider.
module mod_m_counter #(
  parameter int M = 4
) (
  input  logic clk,
  input  logic reset,
  output logic max_tick
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (q == LAST) begin
      q <= '0;
    end else begin
      q <= q + 1'b1;
    end
  end

  assign max_tick = (q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel tick, counts, video_on,
// delayed hsync/vsync and a frame_start pulse.
module vga_sync_gen #(
  parameter int H_DISP     = vga_timing_pkg::H_DISP,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_DISP     = vga_timing_pkg::V_DISP,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter int TICK_DIV   = 4,
  parameter int SYNC_DELAY = 2,
  parameter int SYNC_POL   = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  import vga_timing_pkg::*;

  localparam int HT = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISP + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);

  localparam logic [9:0] HR_LO = 10'(H_DISP + H_FRONT);
  localparam logic [9:0] HR_HI =
    10'(H_DISP + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VR_LO = 10'(V_DISP + V_FRONT);
  localparam logic [9:0] VR_HI =
    10'(V_DISP + V_FRONT + V_SYNC - 1);

  localparam logic  POL  = 1'(SYNC_POL);
  localparam sync_t IDLE = {~POL, ~POL};

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       h_end;
  logic       v_end;
  logic       h_ret;
  logic       v_ret;
  sync_t      raw;

  sync_t [SYNC_DELAY-1:0] pipe;

  mod_m_counter #(
    .M(TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .max_tick(p_tick)
  );

  assign h_end = (h_count == H_LAST);
  assign v_end = (v_count == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
    end else if (p_tick) begin
      h_count <= h_end ? '0 : h_count + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_count <= '0;
    end else if (p_tick && h_end) begin
      v_count <= v_end ? '0 : v_count + 10'd1;
    end
  end

  assign pixel_x  = h_count;
  assign pixel_y  = v_count;
  assign video_on = (h_count < H_VIS) &&
                    (v_count < V_VIS);

  assign h_ret = (h_count >= HR_LO) &&
                 (h_count <= HR_HI);
  assign v_ret = (v_count >= VR_LO) &&
                 (v_count <= VR_HI);

  always_comb begin
    raw    = IDLE;
    raw.hs = sync_level(h_ret, POL);
    raw.vs = sync_level(v_ret, POL);
  end

  // Runs every clk so the lag matches the RGB pipeline depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= {SYNC_DELAY{IDLE}};
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign hsync = pipe[SYNC_DELAY-1].hs;
  assign vsync = pipe[SYNC_DELAY-1].vs;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= p_tick && h_end && v_end;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny
// timing instance for frame, polarity and mid-frame reset.
module tb_vga_sync_gen;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  localparam int S_TICK = 0;
  localparam int S_X    = 1;
  localparam int S_Y    = 2;
  localparam int S_VO   = 3;
  localparam int S_HS   = 4;
  localparam int S_VS   = 5;
  localparam int S_FS   = 6;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  logic       pt_a, vo_a, hs_a, vs_a, fs_a;
  logic [9:0] px_a, py_a;
  logic       pt_b, vo_b, hs_b, vs_b, fs_b;
  logic [9:0] px_b, py_b;

  int cyc_a = 0;
  int cyc_b = 0;
  int n_tests = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .p_tick     (pt_a),
    .pixel_x    (px_a),
    .pixel_y    (py_a),
    .video_on   (vo_a),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .frame_start(fs_a)
  );

  // 10x7 raster, 2 clks/pixel, active-high sync, 1 clk lag.
  vga_sync_gen #(
    .H_DISP(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISP(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .TICK_DIV(2), .SYNC_DELAY(1), .SYNC_POL(1)
  ) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .p_tick     (pt_b),
    .pixel_x    (px_b),
    .pixel_y    (py_b),
    .video_on   (vo_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .frame_start(fs_b)
  );

  // clk index: 1 = the clk following the last reset edge
  always @(posedge clk) cyc_a <= reset_a ? 1 : cyc_a + 1;
  always @(posedge clk) cyc_b <= reset_b ? 1 : cyc_b + 1;

  function automatic string sname(input int s);
    case (s)
      S_TICK:  return "p_tick";
      S_X:     return "pixel_x";
      S_Y:     return "pixel_y";
      S_VO:    return "video_on";
      S_HS:    return "hsync";
      S_VS:    return "vsync";
      default: return "frame_start";
    endcase
  endfunction

  function automatic int get_a(input int s);
    case (s)
      S_TICK:  return int'(pt_a);
      S_X:     return int'(px_a);
      S_Y:     return int'(py_a);
      S_VO:    return int'(vo_a);
      S_HS:    return int'(hs_a);
      S_VS:    return int'(vs_a);
      default: return int'(fs_a);
    endcase
  endfunction

  function automatic int get_b(input int s);
    case (s)
      S_TICK:  return int'(pt_b);
      S_X:     return int'(px_b);
      S_Y:     return int'(py_b);
      S_VO:    return int'(vo_b);
      S_HS:    return int'(hs_b);
      S_VS:    return int'(vs_b);
      default: return int'(fs_b);
    endcase
  endfunction

  task automatic ea(input int c, input int s, input int v);
    q_a.push_back('{c, s, v});
  endtask

  task automatic eb(input int c, input int s, input int v);
    q_b.push_back('{c, s, v});
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (q_a.size() > 0 && q_a[0].cyc <= cyc_a) begin
      e = q_a.pop_front();
      act = get_a(e.sig);
      n_tests++;
      if (e.cyc != cyc_a || act != e.val) begin
        n_fail++;
        $display("FAIL A.%s clk %0d (at %0d): got %0d want %0d",
                 sname(e.sig), e.cyc, cyc_a, act, e.val);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (q_b.size() > 0 && q_b[0].cyc <= cyc_b) begin
      e = q_b.pop_front();
      act = get_b(e.sig);
      n_tests++;
      if (e.cyc != cyc_b || act != e.val) begin
        n_fail++;
        $display("FAIL B.%s clk %0d (at %0d): got %0d want %0d",
                 sname(e.sig), e.cyc, cyc_b, act, e.val);
      end
    end
  end

  initial begin
    exp_t e;

    // default instance: reset state and first ticks
    ea(1, S_TICK, 0); ea(1, S_X, 0); ea(1, S_Y, 0);
    ea(1, S_VO, 1); ea(1, S_HS, 1); ea(1, S_VS, 1);
    ea(1, S_FS, 0);
    ea(2, S_HS, 1); ea(3, S_TICK, 0); ea(4, S_TICK, 1);
    ea(4, S_X, 0);
    ea(5, S_TICK, 0); ea(5, S_X, 1); ea(7, S_TICK, 0);
    ea(8, S_TICK, 1); ea(8, S_HS, 1); ea(8, S_VS, 1);
    ea(2560, S_X, 639); ea(2560, S_VO, 1);
    ea(2561, S_X, 640); ea(2561, S_VO, 0);
    ea(2624, S_X, 655); ea(2625, S_X, 656);
    ea(2626, S_HS, 1); ea(2627, S_HS, 0);
    ea(3010, S_HS, 0); ea(3011, S_HS, 1);
    ea(3200, S_X, 799); ea(3200, S_Y, 0);
    ea(3200, S_VO, 0);
    ea(3201, S_X, 0); ea(3201, S_Y, 1);
    ea(3201, S_VO, 1); ea(3201, S_VS, 1);
    ea(3201, S_FS, 0);

    // small instance: reset state, idle sync level 0
    eb(1, S_TICK, 0); eb(1, S_X, 0); eb(1, S_Y, 0);
    eb(1, S_VO, 1); eb(1, S_HS, 0); eb(1, S_VS, 0);
    eb(1, S_FS, 0);
    eb(2, S_TICK, 1); eb(3, S_X, 1); eb(3, S_TICK, 0);
    eb(8, S_VO, 1); eb(9, S_VO, 0);
    eb(13, S_HS, 0); eb(14, S_HS, 1);
    eb(19, S_HS, 1); eb(20, S_HS, 0);
    eb(20, S_X, 9); eb(20, S_Y, 0);
    eb(21, S_X, 0); eb(21, S_Y, 1);
    eb(47, S_VO, 1); eb(61, S_VO, 0);
    eb(81, S_VS, 0); eb(82, S_VS, 1);
    eb(121, S_VS, 1); eb(122, S_VS, 0);
    eb(140, S_FS, 0); eb(140, S_X, 9); eb(140, S_Y, 6);
    eb(141, S_FS, 1); eb(141, S_X, 0); eb(141, S_Y, 0);
    eb(142, S_FS, 0);
    eb(280, S_FS, 0); eb(281, S_FS, 1); eb(282, S_FS, 0);
    eb(395, S_X, 7); eb(395, S_Y, 5);
    eb(395, S_HS, 1); eb(395, S_VS, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // one-clk reset of the small instance mid-retrace
    do @(negedge clk); while (cyc_b < 395);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    eb(1, S_TICK, 0); eb(1, S_X, 0); eb(1, S_Y, 0);
    eb(1, S_VO, 1); eb(1, S_HS, 0); eb(1, S_VS, 0);
    eb(1, S_FS, 0);
    eb(2, S_TICK, 1); eb(2, S_HS, 0); eb(2, S_FS, 0);
    eb(3, S_X, 1);
    eb(13, S_HS, 0); eb(14, S_HS, 1);
    @(negedge clk);
    reset_b = 1'b0;

    do @(negedge clk); while (cyc_a < 3215);
    #1;

    while (q_a.size() > 0) begin
      e = q_a.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL A.%s clk %0d: never checked, want %0d",
               sname(e.sig), e.cyc, e.val);
    end
    while (q_b.size() > 0) begin
      e = q_b.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL B.%s clk %0d: never checked, want %0d",
               sname(e.sig), e.cyc, e.val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
